// File: rtl/mod_n_qns_pkg.sv
// mod_n_qns_pkg: shared types, defaults and helpers for the noise-shaping quantizer family.
package mod_n_qns_pkg;
  localparam int DEF_NLEV = 4;
  localparam int DEF_LSB_SHIFT = 14;
  localparam int ST_W = 32;
  localparam int CNT_W = 8;
  typedef struct packed {
    logic signed [ST_W-1:0] e1;
    logic signed [ST_W-1:0] e2;
    logic signed [ST_W-1:0] e3;
    logic [CNT_W-1:0] ovl_cnt;
  } chan_t;
  // Signed coefficient of e_k in x - NTF residue: (-1)^(k+1) * C(order, k), zero above order.
  function automatic int ntf_coef(input int order, input int k);
    int c;
    c = 1;
    for (int i = 0; i < k; i++) c = c * (order - i) / (i + 1);
    return (k % 2 == 1) ? c : -c;
  endfunction
  function automatic longint ovl_thr(input int nlev, input int shift);
    return longint'(nlev) << shift;
  endfunction
endpackage

// File: rtl/mod_n_qns_quant.sv
// mod_n_qns_quant: combinational mid-rise bipolar multi-level quantizer with overload flag.
module mod_n_qns_quant
  import mod_n_qns_pkg::*;
#(
  parameter int YW = 23,
  parameter int IN_W = 19,
  parameter int NLEV = DEF_NLEV,
  parameter int LSB_SHIFT = DEF_LSB_SHIFT,
  parameter int OUT_W = $clog2(NLEV) + 1
) (
  input  logic signed [YW-1:0]    yy,
  output logic signed [OUT_W-1:0] code,
  output logic signed [IN_W-1:0]  scaled,
  output logic                    ovl
);
  localparam logic signed [YW-1:0] QMAX = YW'(NLEV / 2 - 1);
  localparam logic signed [YW-1:0] QMIN = YW'(-(NLEV / 2));
  localparam logic signed [YW-1:0] OVL = YW'(ovl_thr(NLEV, LSB_SHIFT));
  localparam logic signed [YW-1:0] NOVL = -OVL;
  logic signed [YW-1:0] q, qc;
  // Arithmetic shift is floor division, so code = 2*q+1 lands on the odd level above each threshold.
  always_comb begin
    q = yy >>> (LSB_SHIFT + 1);
    qc = (q > QMAX) ? QMAX : (q < QMIN) ? QMIN : q;
    code = OUT_W'((qc <<< 1) + YW'(1));
    scaled = IN_W'(code) <<< LSB_SHIFT;
    ovl = (yy > OVL) || (yy < NOVL);
  end
endmodule

// File: rtl/mod_n_qns.sv
// mod_n_qns: multi-channel error-feedback delta-sigma quantizer, NTF (1 - z^-1)^ORDER.
module mod_n_qns
  import mod_n_qns_pkg::*;
#(
  parameter int IN_W = 19,
  parameter int NLEV = DEF_NLEV,
  parameter int OUT_W = $clog2(NLEV) + 1,
  parameter int LSB_SHIFT = DEF_LSB_SHIFT,
  parameter int ORDER = 2,
  parameter int NCH = 2,
  parameter int CH_W = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int OVL_LIMIT = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic [CH_W-1:0]         in_ch,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    out_valid,
  output logic [CH_W-1:0]         out_ch,
  output logic signed [OUT_W-1:0] out_code,
  output logic signed [IN_W-1:0]  out_scaled,
  output logic                    out_overload,
  output logic                    out_reinit
);
  localparam int YW = IN_W + ORDER + 2;
  localparam int EW = IN_W + 2;
  localparam logic signed [YW-1:0] K1 = YW'(ntf_coef(ORDER, 1));
  localparam logic signed [YW-1:0] K2 = YW'(ntf_coef(ORDER, 2));
  localparam logic signed [YW-1:0] K3 = YW'(ntf_coef(ORDER, 3));
  localparam logic signed [YW-1:0] EMAX = (YW'(1) <<< (EW - 1)) - YW'(1);
  localparam logic signed [YW-1:0] EMIN = -EMAX - YW'(1);
  if (ORDER < 1 || ORDER > 3) begin : g_bad_order
    $error("mod_n_qns: ORDER must be 1..3");
  end
  if (NCH < 1 || NCH > 16 || EW > ST_W || OVL_LIMIT < 1 || OVL_LIMIT >= 2 ** CNT_W) begin : g_bad_cfg
    $error("mod_n_qns: unsupported NCH, IN_W or OVL_LIMIT");
  end
  chan_t st [NCH];
  chan_t cur, nxt;
  logic acc, ovl, reinit;
  logic signed [YW-1:0] yy, err, esat;
  logic signed [OUT_W-1:0] code;
  logic signed [IN_W-1:0] scaled;
  assign acc = in_valid && (32'(in_ch) < NCH);
  assign cur = acc ? st[in_ch] : '0;
  assign yy = YW'(in_data) + K1 * YW'(cur.e1) + K2 * YW'(cur.e2) + K3 * YW'(cur.e3);
  mod_n_qns_quant #(
    .YW(YW), .IN_W(IN_W), .NLEV(NLEV), .LSB_SHIFT(LSB_SHIFT), .OUT_W(OUT_W)
  ) u_quant (
    .yy(yy), .code(code), .scaled(scaled), .ovl(ovl)
  );
  // The counter never rests at OVL_LIMIT: the sample that would reach it re-initialises the channel.
  always_comb begin
    err = yy - (YW'(code) <<< LSB_SHIFT);
    esat = (err > EMAX) ? EMAX : (err < EMIN) ? EMIN : err;
    reinit = ovl && (cur.ovl_cnt == CNT_W'(OVL_LIMIT - 1));
    nxt = reinit ? '0 : chan_t'{e1: ST_W'(esat), e2: cur.e1, e3: cur.e2,
                               ovl_cnt: ovl ? cur.ovl_cnt + CNT_W'(1) : '0};
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) st[i] <= '0;
      out_valid <= 1'b0;
      out_ch <= '0;
      out_code <= '0;
      out_scaled <= '0;
      out_overload <= 1'b0;
      out_reinit <= 1'b0;
    end else begin
      out_valid <= acc && !flush;
      if (flush) begin
        for (int i = 0; i < NCH; i++) st[i] <= '0;
      end else if (acc) begin
        st[in_ch] <= nxt;
        out_ch <= in_ch;
        out_code <= code;
        out_scaled <= scaled;
        out_overload <= ovl;
        out_reinit <= reinit;
      end
    end
  end
endmodule

// File: tb/tb_mod_n_qns.sv
// tb_mod_n_qns: directed self-checking bench for mod_n_qns (defaults, plus an ORDER=1 three-channel instance).
module tb_mod_n_qns;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;
  logic a_flush = 1'b0, a_v = 1'b0, a_ch = 1'b0;
  logic signed [18:0] a_d = '0;
  logic a_ov, a_och, a_ovl, a_ri;
  logic signed [2:0] a_code;
  logic signed [18:0] a_sc;
  logic b_flush = 1'b0, b_v = 1'b0;
  logic [1:0] b_ch = '0;
  logic signed [18:0] b_d = '0;
  logic b_ov, b_ovl, b_ri;
  logic [1:0] b_och;
  logic signed [2:0] b_code;
  logic signed [18:0] b_sc;
  int n_chk = 0;
  int n_fail = 0;
  int seq0 [4] = '{1, -1, -1, 1};
  int seq1 [8] = '{1, -1, 3, -1, -1, 3, -1, 1};
  int seqb [4] = '{1, 1, -1, 1};
  longint sum;

  mod_n_qns u_a (
    .clock(clock), .reset_n(reset_n), .flush(a_flush), .in_valid(a_v), .in_ch(a_ch), .in_data(a_d),
    .out_valid(a_ov), .out_ch(a_och), .out_code(a_code), .out_scaled(a_sc),
    .out_overload(a_ovl), .out_reinit(a_ri)
  );
  mod_n_qns #(.ORDER(1), .NCH(3)) u_b (
    .clock(clock), .reset_n(reset_n), .flush(b_flush), .in_valid(b_v), .in_ch(b_ch), .in_data(b_d),
    .out_valid(b_ov), .out_ch(b_och), .out_code(b_code), .out_scaled(b_sc),
    .out_overload(b_ovl), .out_reinit(b_ri)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", a_ov, 0);
    chk("rst_code", a_code, 0);
    chk("rst_scaled", a_sc, 0);
    chk("rst_ovl", a_ovl, 0);
    chk("rst_reinit", a_ri, 0);
    reset_n = 1'b1;
    a_v = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_ch = 1'b0; a_d = 0;
      cyc();
      chk("zero_valid", a_ov, 1);
      chk("zero_code", a_code, seq0[i % 4]);
      chk("zero_scaled", a_sc, seq0[i % 4] * 16384);
      chk("zero_ovl", a_ovl, 0);
    end
    sum = 0;
    for (int i = 0; i < 64; i++) begin
      a_ch = 1'b1; a_d = 8192;
      cyc();
      if (i == 0) chk("ilv_ch1", a_och, 1);
      if (i < 8) chk("ilv_ch1_code", a_code, seq1[i]);
      sum += a_sc;
      a_ch = 1'b0; a_d = 0;
      cyc();
      if (i == 0) chk("ilv_ch0", a_och, 0);
      if (i < 8) chk("ilv_ch0_code", a_code, seq0[i % 4]);
    end
    chk("ilv_ch1_sum", sum, 64 * 8192);
    for (int i = 1; i <= 32; i++) begin
      a_ch = 1'b0; a_d = 262143;
      cyc();
      chk("ovl_flag", a_ovl, 1);
      chk("ovl_code", a_code, 3);
      chk("ovl_reinit", a_ri, (i % 16 == 0) ? 1 : 0);
      a_ch = 1'b1; a_d = 0;
      cyc();
      chk("ovl_ch1_code", a_code, seq0[(i - 1) % 4]);
      chk("ovl_ch1_flag", a_ovl, 0);
      chk("ovl_ch1_reinit", a_ri, 0);
    end
    for (int i = 0; i < 4; i++) begin
      a_ch = 1'b0; a_d = 0;
      cyc();
      chk("post_reinit_code", a_code, seq0[i]);
    end
    cyc();
    chk("pre_flush_code", a_code, 1);
    a_flush = 1'b1;
    cyc();
    chk("flush_valid", a_ov, 0);
    a_flush = 1'b0;
    cyc();
    chk("post_flush_valid", a_ov, 1);
    chk("post_flush_code", a_code, 1);
    cyc();
    chk("pre_rst_code", a_code, -1);
    a_v = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", a_ov, 0);
    chk("arst_code", a_code, 0);
    chk("arst_scaled", a_sc, 0);
    #1 reset_n = 1'b1;
    a_v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("post_rst_code", a_code, seq0[i]);
    end
    a_v = 1'b0;
    b_v = 1'b1; b_ch = 2'd0; b_d = 8192;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("o1_code", b_code, seqb[i]);
      chk("o1_scaled", b_sc, seqb[i] * 16384);
    end
    b_ch = 2'd3; b_d = 262143;
    cyc();
    chk("badch_valid", b_ov, 0);
    chk("badch_hold", b_code, 1);
    b_ch = 2'd0; b_d = 8192;
    for (int i = 2; i < 8; i++) begin
      cyc();
      chk("o1_valid", b_ov, 1);
      chk("o1_code", b_code, seqb[i % 4]);
      chk("o1_ch", b_och, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mod_n_qns.md
Name: mod_n_qns

Overview:
- Parametrised error-feedback noise-shaping quantizer (delta-sigma modulator), the successor to the fixed 2nd-order, 4-level, single-channel modulator.
- Noise transfer function is (1 - z^-1)^ORDER with ORDER in 1..3. Quantizer is mid-rise bipolar with NLEV levels.
- Holds per-channel state for NCH time-multiplexed channels.
- Adds overload detection, automatic per-channel state re-initialisation on sustained overload, and a synchronous flush.
- Sits between the fixed-point filter output, s(IN_W, IN_W-4), and the DAC/QNS level encoder.

Parameters:
- IN_W, 19: input and out_scaled width, signed.
- NLEV, 4: quantizer level count; even, power of 2, at least 2.
- OUT_W, $clog2(NLEV)+1: signed code width.
- LSB_SHIFT, 14: scaled level = code <<< LSB_SHIFT. Requirement: (NLEV-1)<<LSB_SHIFT < 2^(IN_W-1).
- ORDER, 2: noise-shaping order, 1..3. Any other value is an elaboration error.
- NCH, 2: channel count, 1..16.
- CH_W, max(1,$clog2(NCH)): channel index width.
- OVL_LIMIT, 16: consecutive overload samples per channel before state re-init.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all channel state and counters.
- in_valid  in  1  sample strobe.
- in_ch  in  CH_W  channel of sample. Values >= NCH are ignored (treated as in_valid=0).
- in_data  in  IN_W  signed sample.
- out_valid  out  1  result strobe.
- out_ch  out  CH_W  channel of result.
- out_code  out  OUT_W  signed odd quantizer code, range ±1..±(NLEV-1).
- out_scaled  out  IN_W  out_code <<< LSB_SHIFT.
- out_overload  out  1  overload on this sample.
- out_reinit  out  1  channel state was cleared by this sample.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All outputs 0.
  - All error-history registers e1,e2,e3 and overload counters 0, for every channel.
- Latency: 1 cycle. Sample accepted at edge N produces out_valid=1 with its results after edge N. Otherwise out_valid=0, and the other outputs hold their last values.
- Throughput: one sample per cycle, any channel order, back-to-back same channel allowed. State read and update are in the same cycle, so there is no hazard.
- Loop sum, width IN_W+ORDER+2 signed, sign-extended:
  - ORDER1: yy = x + e1
  - ORDER2: yy = x + 2e1 - e2
  - ORDER3: yy = x + 3e1 - 3e2 + e3
  - e1, e2, e3 are the previous errors of channel in_ch.
- Quantizer, with S=LSB_SHIFT:
  - code = 2*floor(yy/2^(S+1)) + 1, clamped to ±(NLEV-1).
  - Equivalently, code k+2 is chosen over k iff yy >= (k+1)*2^S.
  - For the defaults, the thresholds are -32768, 0 and 32768 (a tie goes to the upper code).
- Error: e = yy - (code<<<S). Saturate to IN_W+2 bits signed before storing.
- History update on an accepted sample: e3<=e2, e2<=e1, e1<=e. Only channel in_ch is updated.
- Overload: out_overload = |yy| > NLEV*2^S (65536 for the defaults).
  - An overload sample increments the channel counter, saturating at OVL_LIMIT.
  - A non-overload sample clears the counter.
- Re-init: when an accepted overload sample brings the counter to OVL_LIMIT:
  - out_reinit=1.
  - That channel's e1..e3 and counter are written to 0 instead of the normal update.
  - out_code and out_scaled for that sample are still the quantized values.
- Flush: flush=1 at an edge zeroes all channel state and counters.
  - A concurrent in_valid sample is dropped: out_valid=0 on the next cycle. Flush has priority.
- reset_n deasserting mid-stream: the first accepted sample behaves exactly as after power-up.

Decomposition:
- Package mod_n_qns_pkg holds:
  - the function computing binomial NTF coefficients for ORDER;
  - localparams for the threshold and overload limit derived from NLEV and LSB_SHIFT;
  - the channel state struct {e1,e2,e3,ovl_cnt}.
- Sub-module mod_n_qns_quant is the combinational multi-level quantizer: yy -> code, scaled level, overload flag. It is reusable by future QNS variants.
- The state array, loop sum and control stay in the top module.

Test Plan:
- Defaults, ch0, in_data=0 continuous → out_code repeats +1,-1,-1,+1 (period 4); out_scaled repeats 16384,-16384,-16384,16384; no overload.
- Interleave ch0 (in_data=0) and ch1 (in_data=8192), alternating cycles → each channel's stream is identical to its single-channel run; ch1 mean of out_scaled over 64 samples equals 8192.
- ORDER=1, in_data=8192 → out_code repeats +1,+1,-1,+1 and yy repeats 8192,0,-8192,16384.
- ch0 in_data=262143 continuous → out_overload=1 on every sample; out_reinit=1 on samples 16, 32, ...; state is zero after each re-init; ch1 is unaffected.
- flush and in_valid in the same cycle → out_valid=0 next cycle; the following ch0 sample with in_data=0 gives out_code=+1 (fresh-state sequence).
- reset_n pulsed low asynchronously mid-stream → all outputs 0 with no clock edge; after release, in_data=0 reproduces +1,-1,-1,+1. Also apply in_ch=NCH with in_valid=1 → out_valid stays 0 and no state changes.
